fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Sequences the FFT core's AXI-stream slave channels. After reset it issues one configuration word. It then gates a 16-bit real sample stream into 1024-point frames with `tlast`, and tracks the core's output stream to detect frame completion. It sits between the sample source and `FFT_Control_3`-style FFT wrappers, replacing free-running testbench stimulus with a handshaked frame scheduler.

## Interface
Parameters:
- `NFFT`, 1024: points per frame (power of two, 8..65536)
- `DATA_W`, 16: real sample width
- `CFG_WORD`, 16'h0001: config word sent after reset (bit0 = forward transform)

Ports:
- `clk`  in  1  single system clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to process frames
- `continuous`  in  1  when 1, frames follow back-to-back until cleared
- `in_data`  in  DATA_W  real sample from source
- `in_valid`  in  1  sample valid
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`
- `s_axis_config_tdata`  out  16  config word to core
- `s_axis_config_tvalid`  out  1  config valid
- `s_axis_config_tready`  in  1  core ready for config
- `s_axis_data_tdata`  out  32  {16'h0000 imag, real sample sign-extended/truncated to 16}
- `s_axis_data_tvalid`  out  1  data valid
- `s_axis_data_tlast`  out  1  last sample of frame
- `s_axis_data_tready`  in  1  core ready for data
- `m_axis_data_tvalid`  in  1  core output beat valid
- `m_axis_data_tlast`  in  1  core output last beat
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse when a full output frame has been observed
- `frame_cnt`  out  16  completed frames, wraps at 65535→0
- `err_len`  out  1  sticky: output `tlast` count ≠ NFFT, or beat NFFT arrived without `tlast`

## Operation
- States:
  - CONFIG: entered on reset release. Holds `s_axis_config_tvalid`=1 until `s_axis_config_tready`, then goes to IDLE.
  - IDLE: waits for `start`, then goes to LOAD. `start` clears `err_len`.
  - LOAD: forwards samples and counts accepted beats in `in_cnt`.
  - DRAIN: waits for the last output beat.
- LOAD:
  - `s_axis_data_tvalid = in_valid`
  - `in_ready = s_axis_data_tready`
  - `s_axis_data_tlast = (in_cnt == NFFT-1)`
  - On an accepted beat with `tlast`: `in_cnt`→0, go to DRAIN.
- Output counter `out_cnt` counts beats with `m_axis_data_tvalid` in any state. The counter does not gate the core, because the core has no output backpressure.
- Completion:
  - On a beat with `tlast`, or when `out_cnt` reaches NFFT-1 on a valid beat, `out_cnt`→0 and a frame completes.
  - If the count and `tlast` disagree, set `err_len`.
  - A completed frame pulses `frame_done` and increments `frame_cnt`.
- DRAIN exit on frame completion:
  - `continuous`=1: go to LOAD.
  - `continuous`=0: go to IDLE.
- `start` outside IDLE is ignored.
- Simultaneous `start` and frame completion in IDLE: both take effect, and `err_len` clears before any new error is set.

## Timing
- Reset values:
  - State = CONFIG; `in_cnt` = `out_cnt` = 0; `frame_cnt` = 0.
  - `s_axis_config_tvalid` = 1 one cycle after reset deasserts. It is 0 while `rst` is high.
  - All other outputs are 0.
- Data path is combinational from `in_data`/`in_valid`/`s_axis_data_tready`: zero-cycle latency, no buffering.
- `s_axis_config_tdata` = CFG_WORD constant.
- `frame_done` and `frame_cnt` update in the cycle after the completing output beat (registered).
- `busy` is registered from state.
- AXI rules: valid never depends on ready, except `in_ready` passes ready through. Config `tvalid` holds until handshake.
- Reset mid-frame aborts the frame. After release, the block re-sends config. A partial input frame is never completed.

## Structure
- Shared package `fft_pkg`: state enum (CONFIG, IDLE, LOAD, DRAIN), default NFFT, CFG_WORD, and `$clog2(NFFT)` counter width.
- One sub-module, `fft_beat_counter`: a modulo-NFFT counter with enable and terminal-count flag. It is instantiated for both `in_cnt` and `out_cnt`.

## Test plan
- Reset release with `s_axis_config_tready` low for 5 cycles, then high → `s_axis_config_tvalid` held 5 cycles, one handshake, state IDLE, `busy`=0.
- `start` with 1024 continuous samples (ramp 0..1023) and tready=1 → `tlast` on sample 1023 only; `tdata[31:16]`=0; DRAIN. Then 1024 output beats with `tlast` on last → `frame_done` pulse, `frame_cnt`=1, IDLE.
- tready toggling 1/0 every cycle during LOAD → exactly 1024 accepted beats. `in_valid` stalls do not advance `in_cnt`. `tlast` stays correct.
- `continuous`=1 for 3 frames → LOAD re-entered without IDLE, `frame_cnt`=3. `continuous` cleared during frame 3 → IDLE after it.
- Output `tlast` injected at beat 1000 → `err_len`=1 and `frame_done` pulse. Next `start` → `err_len`=0.
- `rst` asserted mid-LOAD at sample 500 → all outputs 0. After release, config re-sent and `frame_cnt`=0.

Source files
------------

// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared types and defaults for the FFT frame sequencer slice.
//   fft_state_t      : sequencer states (CONFIG, IDLE, LOAD, DRAIN)
//   NFFT_DEFAULT     : default points per frame
//   CFG_WORD_DEFAULT : default configuration word (bit0 = forward transform)
//   CNT_W_DEFAULT    : beat counter width for the default frame size
//   cnt_width()      : beat counter width for an arbitrary frame size
// ----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_DRAIN  = 2'd3
    } fft_state_t;

    localparam int          NFFT_DEFAULT     = 1024;
    localparam logic [15:0] CFG_WORD_DEFAULT = 16'h0001;
    localparam int          CNT_W_DEFAULT    = $clog2(NFFT_DEFAULT);

    // Counter width needed to index n beats (n is a power of two >= 8).
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// ----------------------------------------------------------------------------
// fft_beat_counter
// Modulo-N beat counter with enable, synchronous clear and terminal-count flag.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   clr   : synchronous clear to zero (wins over en)
//   en    : count one beat
//   count : current beat index, 0..N-1
//   tc    : count == N-1 (the next enabled beat is the last of the frame)
// ----------------------------------------------------------------------------
module fft_beat_counter
    import fft_pkg::*;
#(
    parameter int N = NFFT_DEFAULT,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_r;

    // Beat index register; wraps from N-1 back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            count_r <= (count_r == LAST) ? {W{1'b0}} : count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == LAST);

endmodule

// File: rtl/fft_frame_sequencer.sv
// ----------------------------------------------------------------------------
// fft_frame_sequencer
// Drives the FFT core's config and data slave channels: sends one config word
// after reset, then gates a real sample stream into NFFT-point frames with
// tlast and watches the core's output stream for frame completion.
//   clk, rst                  : clock, asynchronous active-high reset
//   start, continuous         : frame request / back-to-back frame mode
//   in_data/in_valid/in_ready : sample source handshake
//   s_axis_config_*           : config channel to the core
//   s_axis_data_*             : data channel to the core ({imag=0, real})
//   m_axis_data_tvalid/tlast  : core output beat observation (no backpressure)
//   busy                      : state is not IDLE (registered)
//   frame_done, frame_cnt     : completion pulse and wrapping frame count
//   err_len                   : sticky output frame length error
// ----------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int          NFFT     = NFFT_DEFAULT,
    parameter int          DATA_W   = 16,
    parameter logic [15:0] CFG_WORD = CFG_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       s_axis_config_tdata,
    output logic              s_axis_config_tvalid,
    input  logic              s_axis_config_tready,
    output logic [31:0]       s_axis_data_tdata,
    output logic              s_axis_data_tvalid,
    output logic              s_axis_data_tlast,
    input  logic              s_axis_data_tready,
    input  logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              err_len
);

    localparam int CNT_W = cnt_width(NFFT);

    fft_state_t  state_r;
    fft_state_t  state_nx_s;

    logic        cfg_valid_r;
    logic        busy_r;
    logic        frame_done_r;
    logic [15:0] frame_cnt_r;
    logic        err_len_r;

    logic [CNT_W-1:0] in_cnt_s;
    logic [CNT_W-1:0] out_cnt_s;
    logic             in_tc_s;
    logic             out_tc_s;
    logic             in_fire_s;
    logic             complete_s;
    logic             len_err_s;
    logic             start_idle_s;
    logic [15:0]      sample16_s;
    logic             unused_cnt_s;

    // Fit the source sample to the core's 16-bit real lane.
    generate
        if (DATA_W >= 16) begin : g_trunc
            assign sample16_s = in_data[15:0];
        end else begin : g_sext
            assign sample16_s = {{(16 - DATA_W){in_data[DATA_W-1]}}, in_data};
        end
    endgenerate

    assign in_fire_s    = (state_r == ST_LOAD) && in_valid && s_axis_data_tready;
    // The core cannot stall its output, so every valid beat is counted.
    assign complete_s   = m_axis_data_tvalid && (m_axis_data_tlast || out_tc_s);
    assign len_err_s    = m_axis_data_tvalid && (m_axis_data_tlast != out_tc_s);
    assign start_idle_s = (state_r == ST_IDLE) && start;

    // Raw counts are not needed beyond the terminal-count flags.
    assign unused_cnt_s = ^{in_cnt_s, out_cnt_s};

    fft_beat_counter #(.N(NFFT), .W(CNT_W)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_r != ST_LOAD),
        .en    (in_fire_s),
        .count (in_cnt_s),
        .tc    (in_tc_s)
    );

    fft_beat_counter #(.N(NFFT), .W(CNT_W)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (m_axis_data_tvalid && m_axis_data_tlast),
        .en    (m_axis_data_tvalid),
        .count (out_cnt_s),
        .tc    (out_tc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CONFIG;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_CONFIG: begin
                // cfg_valid_r is low in the first cycle after reset release.
                if (cfg_valid_r && s_axis_config_tready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CONFIG;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_fire_s && in_tc_s) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (complete_s) begin
                    state_nx_s = continuous ? ST_LOAD : ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_CONFIG;
            end
        endcase
    end

    // Data channel outputs: a zero-latency pass-through while loading.
    always_comb begin
        in_ready           = 1'b0;
        s_axis_data_tvalid = 1'b0;
        s_axis_data_tlast  = 1'b0;
        s_axis_data_tdata  = 32'h0000_0000;
        if (state_r == ST_LOAD) begin
            in_ready           = s_axis_data_tready;
            s_axis_data_tvalid = in_valid;
            s_axis_data_tlast  = in_tc_s;
            s_axis_data_tdata  = {16'h0000, sample16_s};
        end else begin
            in_ready           = 1'b0;
            s_axis_data_tvalid = 1'b0;
            s_axis_data_tlast  = 1'b0;
            s_axis_data_tdata  = 32'h0000_0000;
        end
    end

    // Registered status: config valid, busy, completion pulse/count, length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
            err_len_r    <= 1'b0;
        end else begin
            cfg_valid_r  <= (state_nx_s == ST_CONFIG);
            busy_r       <= (state_nx_s != ST_IDLE);
            frame_done_r <= complete_s;
            if (complete_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            // A start clears the old error first; a same-cycle error still lands.
            if (start_idle_s) begin
                err_len_r <= len_err_s;
            end else begin
                err_len_r <= err_len_r | len_err_s;
            end
        end
    end

    assign s_axis_config_tdata  = CFG_WORD;
    assign s_axis_config_tvalid = cfg_valid_r;
    assign busy                 = busy_r;
    assign frame_done           = frame_done_r;
    assign frame_cnt            = frame_cnt_r;
    assign err_len              = err_len_r;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fft_frame_sequencer
// Directed, self-checking bench for fft_frame_sequencer (NFFT = 1024).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 2 units later, registered outputs right after the edge.
// ----------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] s_axis_config_tdata;
    logic        s_axis_config_tvalid;
    logic        cfg_tready = 1'b0;
    logic [31:0] s_axis_data_tdata;
    logic        s_axis_data_tvalid;
    logic        s_axis_data_tlast;
    logic        data_tready = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_last = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_len;

    int checks = 0;
    int errors = 0;

    fft_frame_sequencer #(.NFFT(N), .DATA_W(16), .CFG_WORD(16'h0001)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .continuous           (continuous),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .s_axis_config_tdata  (s_axis_config_tdata),
        .s_axis_config_tvalid (s_axis_config_tvalid),
        .s_axis_config_tready (cfg_tready),
        .s_axis_data_tdata    (s_axis_data_tdata),
        .s_axis_data_tvalid   (s_axis_data_tvalid),
        .s_axis_data_tlast    (s_axis_data_tlast),
        .s_axis_data_tready   (data_tready),
        .m_axis_data_tvalid   (m_valid),
        .m_axis_data_tlast    (m_last),
        .busy                 (busy),
        .frame_done           (frame_done),
        .frame_cnt            (frame_cnt),
        .err_len              (err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        v;
        logic        r;
        logic [31:0] e_tdata;
        logic        e_tvalid;
        logic        e_ready;
        logic        e_tlast;
    } vec_t;

    vec_t vt [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Ramp samples base..base+n-1 with valid/ready high every cycle.
    task automatic send_frame(input int base, input int n, input string tag);
        int tl_bad;
        int dat_bad;
        int hs_bad;
        tl_bad = 0;
        dat_bad = 0;
        hs_bad = 0;
        for (int i = base; i < base + n; i++) begin
            in_data = 16'(i);
            in_valid = 1'b1;
            data_tready = 1'b1;
            #2;
            if (s_axis_data_tlast !== (i == N - 1)) tl_bad++;
            if (s_axis_data_tdata !== {16'h0000, 16'(i)}) dat_bad++;
            if ((s_axis_data_tvalid !== 1'b1) || (in_ready !== 1'b1)) hs_bad++;
            step();
        end
        in_valid = 1'b0;
        chk({tag, " tlast position"}, 32'(tl_bad), 32'd0);
        chk({tag, " tdata"}, 32'(dat_bad), 32'd0);
        chk({tag, " handshake"}, 32'(hs_bad), 32'd0);
    endtask

    // n output beats, tlast on beat last_idx (-1 = never), optional idle gaps.
    task automatic out_beats(input int n, input int last_idx, input bit gaps, input string tag);
        int early;
        early = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                m_valid = 1'b0;
                m_last = 1'b0;
                step();
                if (frame_done !== 1'b0) early++;
            end
            m_valid = 1'b1;
            m_last = (i == last_idx);
            step();
            if ((i != n - 1) && (frame_done !== 1'b0)) early++;
        end
        m_valid = 1'b0;
        m_last = 1'b0;
        chk({tag, " early frame_done"}, 32'(early), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int mcnt;
        int tl_bad;
        int tl_seen;
        int cyc;

        vt[0] = '{16'h1234, 1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b0};
        vt[1] = '{16'h8001, 1'b0, 1'b1, 32'h0000_8001, 1'b0, 1'b1, 1'b0};
        vt[2] = '{16'hFFFF, 1'b1, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0};
        vt[3] = '{16'h00AA, 1'b0, 1'b0, 32'h0000_00AA, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h7FFF, 1'b1, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0};

        // ---- reset and config handshake with a 5-cycle stall ----
        step();
        step();
        chk("rst cfg_tvalid", 32'(s_axis_config_tvalid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst data_tvalid", 32'(s_axis_data_tvalid), 32'd0);
        rst = 1'b0;
        step();
        chk("cfg tdata", 32'(s_axis_config_tdata), 32'h0001);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("cfg hold %0d", i), 32'(s_axis_config_tvalid), 32'd1);
            step();
        end
        cfg_tready = 1'b1;
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            if (s_axis_config_tvalid && cfg_tready) hs++;
            step();
        end
        cfg_tready = 1'b0;
        chk("cfg handshakes", 32'(hs), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle in_ready", 32'(in_ready), 32'd0);

        // ---- frame A: ramp, tready=1, clean output frame ----
        pulse_start();
        chk("A busy", 32'(busy), 32'd1);
        send_frame(0, N, "A");
        in_valid = 1'b1;
        #2;
        chk("A drain tvalid", 32'(s_axis_data_tvalid), 32'd0);
        chk("A drain in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        out_beats(N, N - 1, 1'b0, "A");
        chk("A frame_done", 32'(frame_done), 32'd1);
        chk("A frame_cnt", 32'(frame_cnt), 32'd1);
        chk("A busy after", 32'(busy), 32'd0);
        chk("A err_len", 32'(err_len), 32'd0);
        step();
        chk("A frame_done pulse", 32'(frame_done), 32'd0);

        // ---- frame B: vector table then tready toggling with valid stalls ----
        pulse_start();
        mcnt = 0;
        for (int k = 0; k < 5; k++) begin
            in_data = vt[k].d;
            in_valid = vt[k].v;
            data_tready = vt[k].r;
            #2;
            chk($sformatf("vec%0d tdata", k), s_axis_data_tdata, vt[k].e_tdata);
            chk($sformatf("vec%0d tvalid", k), 32'(s_axis_data_tvalid), 32'(vt[k].e_tvalid));
            chk($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vt[k].e_ready));
            chk($sformatf("vec%0d tlast", k), 32'(s_axis_data_tlast), 32'(vt[k].e_tlast));
            if (vt[k].v && vt[k].r) mcnt++;
            step();
        end
        tl_bad = 0;
        tl_seen = 0;
        cyc = 0;
        while ((mcnt < N) && (cyc < 5000)) begin
            data_tready = cyc[0];
            in_valid = ((cyc % 7) != 3);
            in_data = 16'(mcnt);
            #2;
            if (s_axis_data_tlast !== (mcnt == N - 1)) tl_bad++;
            if (in_valid && data_tready) begin
                if (s_axis_data_tlast) tl_seen++;
                mcnt++;
            end
            step();
            cyc++;
        end
        chk("B accepted beats", 32'(mcnt), 32'(N));
        chk("B tlast position", 32'(tl_bad), 32'd0);
        chk("B tlast accepted", 32'(tl_seen), 32'd1);
        in_valid = 1'b1;
        data_tready = 1'b1;
        #2;
        chk("B drain tvalid", 32'(s_axis_data_tvalid), 32'd0);
        chk("B drain in_ready", 32'(in_ready), 32'd0);
        chk("B drain busy", 32'(busy), 32'd1);
        step();
        in_valid = 1'b0;
        out_beats(N, N - 1, 1'b1, "B");
        chk("B frame_done", 32'(frame_done), 32'd1);
        chk("B frame_cnt", 32'(frame_cnt), 32'd2);
        step();

        // ---- continuous mode: three frames, cleared during the third ----
        continuous = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                send_frame(0, N / 2, "C3a");
                continuous = 1'b0;
                send_frame(N / 2, N / 2, "C3b");
            end else begin
                send_frame(0, N, $sformatf("C%0d", f + 1));
            end
            out_beats(N, N - 1, 1'b0, $sformatf("C%0d", f + 1));
            chk($sformatf("C%0d frame_done", f + 1), 32'(frame_done), 32'd1);
            chk($sformatf("C%0d frame_cnt", f + 1), 32'(frame_cnt), 32'(3 + f));
            data_tready = 1'b1;
            #2;
            chk($sformatf("C%0d busy", f + 1), 32'(busy), (f < 2) ? 32'd1 : 32'd0);
            chk($sformatf("C%0d in_ready", f + 1), 32'(in_ready), (f < 2) ? 32'd1 : 32'd0);
            step();
        end

        // ---- early output tlast at beat 1000 ----
        pulse_start();
        send_frame(0, N, "E");
        out_beats(1000, 999, 1'b0, "E");
        chk("E frame_done", 32'(frame_done), 32'd1);
        chk("E err_len", 32'(err_len), 32'd1);
        chk("E frame_cnt", 32'(frame_cnt), 32'd6);
        chk("E busy", 32'(busy), 32'd0);
        step();
        chk("E err_len sticky", 32'(err_len), 32'd1);

        // ---- start in IDLE together with a correct completing beat ----
        out_beats(N - 1, -1, 1'b0, "S");
        start = 1'b1;
        m_valid = 1'b1;
        m_last = 1'b1;
        step();
        start = 1'b0;
        m_valid = 1'b0;
        m_last = 1'b0;
        chk("S frame_done", 32'(frame_done), 32'd1);
        chk("S err_len cleared", 32'(err_len), 32'd0);
        chk("S frame_cnt", 32'(frame_cnt), 32'd7);
        chk("S busy", 32'(busy), 32'd1);

        // ---- NFFT output beats without tlast while loading ----
        out_beats(N, -1, 1'b0, "L");
        chk("L frame_done", 32'(frame_done), 32'd1);
        chk("L err_len", 32'(err_len), 32'd1);
        chk("L frame_cnt", 32'(frame_cnt), 32'd8);
        data_tready = 1'b1;
        #2;
        chk("L still loading", 32'(in_ready), 32'd1);
        step();

        // ---- reset at sample 500 of a frame ----
        send_frame(0, 500, "R");
        in_data = 16'h5555;
        in_valid = 1'b1;
        data_tready = 1'b1;
        rst = 1'b1;
        #2;
        chk("R cfg_tvalid", 32'(s_axis_config_tvalid), 32'd0);
        chk("R data_tvalid", 32'(s_axis_data_tvalid), 32'd0);
        chk("R tlast", 32'(s_axis_data_tlast), 32'd0);
        chk("R tdata", s_axis_data_tdata, 32'd0);
        chk("R in_ready", 32'(in_ready), 32'd0);
        chk("R busy", 32'(busy), 32'd0);
        chk("R frame_done", 32'(frame_done), 32'd0);
        chk("R frame_cnt", 32'(frame_cnt), 32'd0);
        chk("R err_len", 32'(err_len), 32'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("R cfg resent", 32'(s_axis_config_tvalid), 32'd1);
        cfg_tready = 1'b1;
        step();
        cfg_tready = 1'b0;
        chk("R cfg done", 32'(s_axis_config_tvalid), 32'd0);
        chk("R idle busy", 32'(busy), 32'd0);
        pulse_start();
        send_frame(0, N, "P");
        out_beats(N, N - 1, 1'b0, "P");
        chk("P frame_done", 32'(frame_done), 32'd1);
        chk("P frame_cnt", 32'(frame_cnt), 32'd1);
        chk("P err_len", 32'(err_len), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
